// File: rtl/formant_pkg.sv
// Shared types and sizing for the formant traceback stage.
package formant_pkg;

  // Traceback controller states
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    CHECK = 3'd3,
    EMIT  = 3'd4,
    DONE  = 3'd5
  } state_t;

  // Default sizing for I=160 frames, FORMANTS=5
  localparam int IDX_W = $clog2(160) + 1;  // signed frame index incl. -1
  localparam int K_W   = $clog2(5);        // formant number 1..FORMANTS

  // One emitted segment; fields wide enough for any sensible parameter set
  typedef struct packed {
    logic [15:0] k;
    logic [15:0] s_frame;
    logic [15:0] e_frame;
  } seg_t;

endpackage

// File: rtl/f_backtrace.sv
// Walks the back-pointer table B(k,i) from the last formant / last frame
// down to formant 1 and emits one (k, start, end) segment per formant.
module f_backtrace
  import formant_pkg::*;
#(
  parameter int BIT_WIDTH    = 32,
  parameter int I            = 160,
  parameter int FORMANTS     = 5,
  parameter int READ_LATENCY = 2
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        start,
  input  logic [$clog2(I)-1:0]        i_last,
  output logic                        rd_en,
  output logic [$clog2(FORMANTS)-1:0] k_rd,
  output logic [$clog2(I)-1:0]        i_rd,
  input  logic [BIT_WIDTH-1:0]        b_rd_data,
  output logic                        seg_valid,
  input  logic                        seg_ready,
  output logic [$clog2(FORMANTS)-1:0] seg_k,
  output logic [$clog2(I)-1:0]        seg_start,
  output logic [$clog2(I)-1:0]        seg_end,
  output logic                        busy,
  output logic                        done,
  output logic                        err
);

  localparam int FW = $clog2(I);
  localparam int IW = FW + 1;
  localparam int KW = $clog2(FORMANTS);
  localparam int CW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  localparam logic signed [IW-1:0] K1   = 1;
  localparam logic signed [IW:0]   ONE  = 1;
  localparam logic signed [IW:0]   TWO  = 2;
  localparam logic signed [IW:0]   NEG1 = -1;

  state_t               r_state, w_next;
  logic signed [IW-1:0] r_i, r_k, r_b;
  logic [CW-1:0]        r_cnt;
  seg_t                 r_seg;
  logic                 r_err;

  logic signed [IW-1:0] w_b, w_kinit;
  logic [IW-1:0]        w_ilast_p1;
  logic signed [IW:0]   w_bx, w_kx, w_ix, w_lo, w_hi;
  logic                 w_ok;
  logic                 w_unused;

  // Pointer decode: b is the sign-extended low IDX bits of the read word
  assign w_b        = signed'(b_rd_data[IW-1:0]);
  assign w_ilast_p1 = {1'b0, i_last} + IW'(1);
  assign w_kinit    = (w_ilast_p1 > IW'(FORMANTS)) ? IW'(FORMANTS) : w_ilast_p1;

  // A pointer is legal when k-2 <= b <= i-1; formant 1 must point to -1
  assign w_bx = r_b;
  assign w_kx = r_k;
  assign w_ix = r_i;
  assign w_lo = w_kx - TWO;
  assign w_hi = w_ix - ONE;
  assign w_ok = (w_bx >= w_lo) && (w_bx <= w_hi) && ((r_k != K1) || (w_bx == NEG1));

  // State register
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) r_state <= IDLE;
    else         r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = REQ;
      REQ:     w_next = WAIT;
      WAIT:    if (r_cnt == '0) w_next = CHECK;
      CHECK:   w_next = w_ok ? EMIT : DONE;
      EMIT:    if (seg_ready) w_next = (r_k == K1) ? DONE : REQ;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Walk registers: current formant/frame, captured pointer, latency count, segment
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_i   <= '0;
      r_k   <= '0;
      r_b   <= '0;
      r_cnt <= '0;
      r_seg <= '0;
      r_err <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_i   <= signed'({1'b0, i_last});
          r_k   <= w_kinit;
          r_err <= 1'b0;
        end
        REQ:  r_cnt <= CW'(READ_LATENCY - 1);
        WAIT: begin
          if (r_cnt == '0) r_b <= w_b;
          else             r_cnt <= r_cnt - CW'(1);
        end
        CHECK: begin
          if (!w_ok) r_err <= 1'b1;
          else       r_seg <= '{k: 16'(r_k), s_frame: 16'(r_b + K1), e_frame: 16'(r_i)};
        end
        EMIT: if (seg_ready && (r_k != K1)) begin
          r_i <= r_b;
          r_k <= r_k - K1;
        end
        default: ;
      endcase
    end
  end

  assign rd_en     = (r_state == REQ);
  assign k_rd      = rd_en ? r_k[KW-1:0] : '0;
  assign i_rd      = rd_en ? r_i[FW-1:0] : '0;
  assign seg_valid = (r_state == EMIT);
  assign seg_k     = r_seg.k[KW-1:0];
  assign seg_start = r_seg.s_frame[FW-1:0];
  assign seg_end   = r_seg.e_frame[FW-1:0];
  assign busy      = (r_state != IDLE);
  assign done      = (r_state == DONE);
  assign err       = r_err;

  assign w_unused = ^{b_rd_data[BIT_WIDTH-1:IW], r_seg.k[15:KW],
                      r_seg.s_frame[15:FW], r_seg.e_frame[15:FW]};

endmodule

// File: tb/tb_f_backtrace.sv
// Self-checking bench for f_backtrace with a small B-table memory model.
module tb_f_backtrace;

  localparam int F  = 3;
  localparam int NI = 8;

  typedef struct {int k; int s; int e;} seg_s;
  typedef struct {int k; int i;} rd_s;

  logic        clk_in = 1'b0;
  logic        rst_in, start, seg_ready;
  logic [2:0]  i_last;
  logic        rd_en, seg_valid, busy, done, err;
  logic [1:0]  k_rd, seg_k;
  logic [2:0]  i_rd, seg_start, seg_end;
  logic [31:0] b_rd_data;

  logic [31:0] btab [0:3][0:7];
  logic [31:0] p0, p1;

  seg_s got_segs[$], exp_segs[$];
  rd_s  got_rds[$],  exp_rds[$];
  int   dcnt;
  int   exp_err;
  int   n_pass = 0;
  int   n_total = 0;
  logic inj_busy;

  always #5 clk_in = ~clk_in;

  f_backtrace #(.BIT_WIDTH(32), .I(NI), .FORMANTS(F), .READ_LATENCY(2)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .start(start), .i_last(i_last),
    .rd_en(rd_en), .k_rd(k_rd), .i_rd(i_rd), .b_rd_data(b_rd_data),
    .seg_valid(seg_valid), .seg_ready(seg_ready), .seg_k(seg_k),
    .seg_start(seg_start), .seg_end(seg_end), .busy(busy), .done(done), .err(err)
  );

  // Two-cycle read memory; filler low nibble decodes to -8 (never a legal pointer)
  always @(posedge clk_in) begin
    p0 <= rd_en ? btab[k_rd][i_rd] : 32'h5A5A_5A58;
    p1 <= p0;
  end
  assign b_rd_data = p1;

  // Stream monitor
  always @(posedge clk_in) begin
    if (rst_in) begin
      if (seg_valid && seg_ready) got_segs.push_back('{int'(seg_k), int'(seg_start), int'(seg_end)});
      if (rd_en) got_rds.push_back('{int'(k_rd), int'(i_rd)});
      if (done) dcnt++;
    end
  end

  function automatic string segs_str(input seg_s q[$]);
    string s = "";
    foreach (q[n]) s = {s, $sformatf("(%0d,%0d,%0d)", q[n].k, q[n].s, q[n].e)};
    return s;
  endfunction

  function automatic string rds_str(input rd_s q[$]);
    string s = "";
    foreach (q[n]) s = {s, $sformatf("(%0d,%0d)", q[n].k, q[n].i)};
    return s;
  endfunction

  // Pointer value as the table defines it: signed 4-bit field in the low bits
  function automatic int ptr(input logic [31:0] w);
    int v = int'(w & 32'hF);
    if (v > 7) v -= 16;
    return v;
  endfunction

  // Reference traceback following the pointer rules directly
  task automatic model(input int il);
    int k, i, b;
    exp_segs.delete(); exp_rds.delete(); exp_err = 0;
    k = (il + 1 < F) ? il + 1 : F;
    i = il;
    forever begin
      exp_rds.push_back('{k, i});
      b = ptr(btab[k][i]);
      if (b < k - 2 || b > i - 1 || (k == 1 && b != -1)) begin exp_err = 1; break; end
      exp_segs.push_back('{k, b + 1, i});
      if (k == 1) break;
      i = b;
      k--;
    end
  endtask

  task automatic fill_random();
    for (int k = 0; k < 4; k++) for (int i = 0; i < NI; i++) btab[k][i] = $urandom;
  endtask

  task automatic set_ptr(input int k, input int i, input int b);
    btab[k][i] = ($urandom & 32'hFFFF_FFF0) | (b & 15);
  endtask

  task automatic basic_table();
    fill_random();
    set_ptr(3, 7, 4); set_ptr(2, 4, 1); set_ptr(1, 1, -1);
  endtask

  // mode 0: ready high, 1: stall 5 cycles per segment, 2: random ready
  task automatic run_walk(input int il, input int mode, input int inj_cyc, input int inj_il);
    int   stall = 0;
    bit   fin = 0;
    logic [7:0] held;
    got_segs.delete(); got_rds.delete(); dcnt = 0; inj_busy = 1'b0;
    @(negedge clk_in); start = 1'b1; i_last = 3'(il); seg_ready = (mode != 1);
    @(negedge clk_in); start = 1'b0;
    for (int cyc = 1; cyc < 2000; cyc++) begin
      @(negedge clk_in);
      start = 1'b0;
      if (cyc == inj_cyc) begin start = 1'b1; i_last = 3'(inj_il); inj_busy = busy; end
      if (mode == 2) seg_ready = ($urandom_range(0, 9) < 6);
      else if (mode == 1) begin
        if (seg_valid) begin
          if (stall == 0) held = {seg_k, seg_start, seg_end};
          else begin
            n_total++;
            if ({seg_k, seg_start, seg_end} !== held)
              $display("FAIL stall_stable got=%h want=%h", {seg_k, seg_start, seg_end}, held);
            else n_pass++;
          end
          if (stall < 5) begin seg_ready = 1'b0; stall++; end
          else seg_ready = 1'b1;
        end else begin
          stall = 0; seg_ready = 1'b0;
        end
      end
      if (done) begin fin = 1; break; end
    end
    n_total++;
    if (!fin) $display("FAIL walk_timeout got=no_done want=done");
    else n_pass++;
    @(negedge clk_in); start = 1'b0; seg_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst_in = 1'b0; start = 1'b0; i_last = '0; seg_ready = 1'b1;
    repeat (3) @(negedge clk_in);
    n_total++;
    if ({rd_en, k_rd, i_rd, seg_valid, seg_k, seg_start, seg_end, busy, done, err} !== 18'd0)
      $display("FAIL reset_outputs got=%h want=0",
               {rd_en, k_rd, i_rd, seg_valid, seg_k, seg_start, seg_end, busy, done, err});
    else n_pass++;
    rst_in = 1'b1;
    @(negedge clk_in);
  endtask

  task automatic test_basic();
    basic_table();
    run_walk(7, 0, -1, 0);
    n_total++;
    if (segs_str(got_segs) != "(3,5,7)(2,2,4)(1,0,1)")
      $display("FAIL basic_segs got=%s want=(3,5,7)(2,2,4)(1,0,1)", segs_str(got_segs));
    else n_pass++;
    n_total++;
    if (rds_str(got_rds) != "(3,7)(2,4)(1,1)")
      $display("FAIL basic_reads got=%s want=(3,7)(2,4)(1,1)", rds_str(got_rds));
    else n_pass++;
    n_total++;
    if (err !== 1'b0 || dcnt !== 1 || done !== 1'b0 || busy !== 1'b0)
      $display("FAIL basic_done got=err%0b/dones%0d/done%0b/busy%0b want=err0/dones1/done0/busy0",
               err, dcnt, done, busy);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    basic_table();
    run_walk(7, 1, -1, 0);
    n_total++;
    if (segs_str(got_segs) != "(3,5,7)(2,2,4)(1,0,1)")
      $display("FAIL bp_segs got=%s want=(3,5,7)(2,2,4)(1,0,1)", segs_str(got_segs));
    else n_pass++;
    n_total++;
    if (rds_str(got_rds) != "(3,7)(2,4)(1,1)")
      $display("FAIL bp_reads got=%s want=(3,7)(2,4)(1,1)", rds_str(got_rds));
    else n_pass++;
    n_total++;
    if (dcnt !== 1) $display("FAIL bp_done got=%0d want=1", dcnt);
    else n_pass++;
  endtask

  task automatic test_short();
    fill_random();
    set_ptr(2, 1, 0); set_ptr(1, 0, -1);
    run_walk(1, 0, -1, 0);
    n_total++;
    if (segs_str(got_segs) != "(2,1,1)(1,0,0)")
      $display("FAIL short_segs got=%s want=(2,1,1)(1,0,0)", segs_str(got_segs));
    else n_pass++;
    n_total++;
    if (rds_str(got_rds) != "(2,1)(1,0)" || dcnt !== 1)
      $display("FAIL short_reads got=%s/%0d want=(2,1)(1,0)/1", rds_str(got_rds), dcnt);
    else n_pass++;
  endtask

  task automatic test_bad_pointer();
    basic_table();
    set_ptr(3, 7, 7);
    run_walk(7, 0, -1, 0);
    n_total++;
    if (err !== 1'b1 || got_segs.size() != 0 || dcnt !== 1)
      $display("FAIL bad_ptr got=err%0b/segs%0d/dones%0d want=err1/segs0/dones1",
               err, got_segs.size(), dcnt);
    else n_pass++;
    set_ptr(3, 7, 4);
    run_walk(7, 0, -1, 0);
    n_total++;
    if (err !== 1'b0 || segs_str(got_segs) != "(3,5,7)(2,2,4)(1,0,1)")
      $display("FAIL bad_ptr_recover got=err%0b/%s want=err0/(3,5,7)(2,2,4)(1,0,1)",
               err, segs_str(got_segs));
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit hit = 0;
    basic_table();
    got_segs.delete(); got_rds.delete(); dcnt = 0;
    seg_ready = 1'b1;
    @(negedge clk_in); start = 1'b1; i_last = 3'd7;
    @(negedge clk_in); start = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk_in);
      if (seg_valid && got_segs.size() == 1) begin hit = 1; break; end
    end
    n_total++;
    if (!hit) $display("FAIL rst_mid_reach got=no_second_emit want=second_emit");
    else n_pass++;
    #1 rst_in = 1'b0;
    #1;
    n_total++;
    if ({rd_en, k_rd, i_rd, seg_valid, seg_k, seg_start, seg_end, busy, done, err} !== 18'd0)
      $display("FAIL rst_mid_outputs got=%h want=0",
               {rd_en, k_rd, i_rd, seg_valid, seg_k, seg_start, seg_end, busy, done, err});
    else n_pass++;
    repeat (2) @(negedge clk_in);
    rst_in = 1'b1;
    repeat (20) @(negedge clk_in);
    n_total++;
    if (dcnt !== 0 || got_segs.size() != 1 || busy !== 1'b0)
      $display("FAIL rst_mid_quiet got=dones%0d/segs%0d/busy%0b want=dones0/segs1/busy0",
               dcnt, got_segs.size(), busy);
    else n_pass++;
    run_walk(7, 0, -1, 0);
    n_total++;
    if (segs_str(got_segs) != "(3,5,7)(2,2,4)(1,0,1)" || err !== 1'b0 || dcnt !== 1)
      $display("FAIL rst_mid_rerun got=%s/err%0b/dones%0d want=(3,5,7)(2,2,4)(1,0,1)/err0/dones1",
               segs_str(got_segs), err, dcnt);
    else n_pass++;
  endtask

  task automatic test_start_busy();
    basic_table();
    set_ptr(3, 3, 1);
    run_walk(7, 0, 1, 3);
    n_total++;
    if (inj_busy !== 1'b1) $display("FAIL busy_inject got=busy%0b want=busy1", inj_busy);
    else n_pass++;
    n_total++;
    if (segs_str(got_segs) != "(3,5,7)(2,2,4)(1,0,1)" || rds_str(got_rds) != "(3,7)(2,4)(1,1)")
      $display("FAIL busy_walk got=%s %s want=(3,5,7)(2,2,4)(1,0,1) (3,7)(2,4)(1,1)",
               segs_str(got_segs), rds_str(got_rds));
    else n_pass++;
    repeat (5) @(negedge clk_in);
    n_total++;
    if (busy !== 1'b0 || dcnt !== 1) $display("FAIL busy_after got=busy%0b/dones%0d want=busy0/dones1", busy, dcnt);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int t = 0; t < 40; t++) begin
      int il, k, i, b, bad;
      fill_random();
      il = $urandom_range(0, 7);
      k = (il + 1 < F) ? il + 1 : F;
      i = il;
      bad = ($urandom_range(0, 3) == 0) ? $urandom_range(1, k) : 0;
      while (k >= 1) begin
        if (k == 1) b = -1;
        else b = $urandom_range(i - 1, k - 2);
        if (k == bad) b = i;
        set_ptr(k, i, b);
        if (k == 1 || k == bad) break;
        i = b;
        k--;
      end
      model(il);
      run_walk(il, 2, -1, 0);
      n_total++;
      if (segs_str(got_segs) != segs_str(exp_segs))
        $display("FAIL rand_segs[%0d] got=%s want=%s", t, segs_str(got_segs), segs_str(exp_segs));
      else n_pass++;
      n_total++;
      if (rds_str(got_rds) != rds_str(exp_rds))
        $display("FAIL rand_reads[%0d] got=%s want=%s", t, rds_str(got_rds), rds_str(exp_rds));
      else n_pass++;
      n_total++;
      if (int'(err) != exp_err || dcnt !== 1)
        $display("FAIL rand_status[%0d] got=err%0b/dones%0d want=err%0d/dones1", t, err, dcnt, exp_err);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_short();
    test_bad_pointer();
    test_reset_mid();
    test_start_busy();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/f_backtrace.md
Name: f_backtrace

Overview:
- Traceback stage downstream of the formant DP iteration block.
- Runs after every F/B iteration for the final frame index is done.
- Walks the stored back-pointer table B(k,i) from the last formant and last frame down to formant 1.
- Emits one segment (formant k, start frame, end frame) per formant on a valid/ready stream. The spectrogram overlay consumes this stream.

Parameters:
- BIT_WIDTH, 32: width of the B table read data word. B is a signed j in the low bits; j = -1 means the segment starts at frame 0.
- I, 160: number of frames.
- FORMANTS, 5: maximum formant count.
- READ_LATENCY, 2: cycles from rd_en to valid b_rd_data.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  reset, asynchronous, active-low
- start  input  1  one-cycle pulse; begin traceback
- i_last  input  $clog2(I)  final frame index, sampled on start
- rd_en  output  1  B table read strobe
- k_rd  output  $clog2(FORMANTS)  B table row (formant)
- i_rd  output  $clog2(I)  B table column (frame)
- b_rd_data  input  BIT_WIDTH  B(k_rd,i_rd), valid READ_LATENCY cycles after rd_en
- seg_valid  output  1  segment fields valid
- seg_ready  input  1  consumer accepts segment
- seg_k  output  $clog2(FORMANTS)  formant number, 1..FORMANTS
- seg_start  output  $clog2(I)  first frame of segment
- seg_end  output  $clog2(I)  last frame of segment
- busy  output  1  high outside IDLE
- done  output  1  one-cycle pulse at end of traceback
- err  output  1  sticky; invalid back-pointer seen; cleared on next accepted start

Behaviour:
- Reset (rst_in low, async): state IDLE. All outputs 0 (rd_en, k_rd, i_rd, seg_*, busy, done, err); internal k, i, b cleared. Reset mid-traceback abandons the walk; no further segments or done.
- Internal signed index width IDX_W = $clog2(I)+1; b = sign-extended low IDX_W bits of b_rd_data.
- IDLE: on start, latch i = i_last, k = min(FORMANTS, i_last+1), clear err, go to REQ. start in any other state is ignored.
- REQ (1 cycle): rd_en=1, k_rd=k, i_rd=i; go to WAIT. rd_en is 0 in every other state.
- WAIT: count READ_LATENCY cycles; capture b on the cycle the data is valid.
- CHECK (1 cycle): pointer is valid iff k-2 <= b <= i-1, and additionally b == -1 when k == 1.
  - Invalid: err<=1, go to DONE; no segment is emitted for this or any later formant.
  - Valid: load seg_k=k, seg_start=b+1, seg_end=i; go to EMIT.
- EMIT: seg_valid=1; fields held stable until seg_valid && seg_ready.
  - On handshake with k==1: go to DONE.
  - On handshake with k>1: i<=b, k<=k-1, go to REQ.
  - seg_valid drops the cycle after the handshake.
- DONE: done=1 for exactly one cycle, then IDLE.
- Segment order: highest formant first; ends are descending and contiguous (seg_end of segment n+1 = seg_start of segment n minus 1).
- Minimum cost per segment with seg_ready tied high: READ_LATENCY+3 cycles.
- busy=1 in REQ, WAIT, CHECK, EMIT and DONE.

Decomposition:
- Shared package formant_pkg holds:
  - state enum {IDLE, REQ, WAIT, CHECK, EMIT, DONE}
  - IDX_W and K_W localparams
  - a segment struct {k, start, end}
- No sub-module required; the READ_LATENCY wait is an internal down-counter.

Test Plan:
- Basic walk (I=8, FORMANTS=3, seg_ready=1). Table: B(3,7)=4, B(2,4)=1, B(1,1)=-1. start with i_last=7 -> segments (3,5,7), (2,2,4), (1,0,1); then done pulse; err=0; reads at (3,7), (2,4), (1,1) only.
- Backpressure, same table. seg_ready low for 5 cycles at each EMIT -> fields stable, exactly 3 handshakes, no extra rd_en while stalled.
- Short input. i_last=1, so k=2. Table: B(2,1)=0, B(1,0)=-1 -> segments (2,1,1), (1,0,0); then done.
- Bad pointer. B(3,7)=7 -> err=1, done pulses, zero segments. A second start with a corrected table -> err clears and normal output follows.
- Reset mid-op. Assert rst_in low during the second EMIT -> all outputs 0 immediately (asynchronous); no done. A new start afterwards runs cleanly.
- start while busy. Pulse start during WAIT with a different i_last -> ignored; the original walk completes unchanged.
